// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Optional counters are enabled with WB_ARB_STATS_EN.
package wb_pkg;

    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int TAG_W  = 4;
    localparam int PTR_W  = 3;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } wb_entry_t;

    function automatic logic [PTR_W-1:0] rr_next(
        input logic [PTR_W-1:0] ptr,
        input int               n
    );
        int nx;
        nx = int'(ptr) + 1;
        if (nx >= n) nx = 0;
        return PTR_W'(nx);
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: up to LANES grants per cycle,
// skipping slots whose register is already granted this cycle.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 6
) (
    input  logic [NUM_SRC-1:0]            occ,
    input  logic [NUM_SRC-1:0][REG_W-1:0] regs,
    input  logic [PTR_W-1:0]              rr_ptr,
    output logic [LANES-1:0][PTR_W-1:0]   lane_idx,
    output logic [LANES-1:0]              lane_vld,
    output logic [NUM_SRC-1:0]            grant,
    output logic [NUM_SRC-1:0]            conflict,
    output logic [PTR_W-1:0]              next_ptr
);

    logic [LANES-1:0][REG_W-1:0] g_reg;
    logic [PTR_W-1:0]            idx;
    logic [2:0]                  cnt;
    logic                        hit;

    always_comb begin
        grant    = '0;
        conflict = '0;
        lane_vld = '0;
        lane_idx = '0;
        g_reg    = '0;
        next_ptr = rr_ptr;
        cnt      = '0;
        idx      = '0;
        hit      = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
            hit = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if ((3'(l) < cnt) && (g_reg[l] == regs[idx]))
                    hit = 1'b1;
            end
            if (occ[idx]) begin
                if (hit) begin
                    conflict[idx] = 1'b1;
                end else if (cnt < 3'(LANES)) begin
                    grant[idx]           = 1'b1;
                    lane_vld[cnt[1:0]]   = 1'b1;
                    lane_idx[cnt[1:0]]   = idx;
                    g_reg[cnt[1:0]]      = regs[idx];
                    next_ptr             = rr_next(idx, NUM_SRC);
                    cnt                  = cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Per-source holding slots scheduled onto the 4-lane register-file
// write port. WB_ARB_STATS_EN adds grant/conflict counters.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_SRC = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid_flat,
    output logic [NUM_SRC-1:0]        src_ready_flat,
    input  logic [NUM_SRC*REG_W-1:0]  src_reg_flat,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_flat,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag_flat,
    output logic [LANES-1:0]          wr_en_flat,
    output logic [LANES*REG_W-1:0]    wr_reg_flat,
    output logic [LANES*DATA_W-1:0]   wr_data_flat,
    output logic [LANES*TAG_W-1:0]    wr_tag_flat
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0]               stat_grants,
    output logic [31:0]               stat_conflicts
`endif
);

    wb_entry_t [NUM_SRC-1:0]            slot;
    logic [NUM_SRC-1:0]                 occ;
    logic [NUM_SRC-1:0][REG_W-1:0]      regs;
    logic [PTR_W-1:0]                   rr_ptr;
    logic [PTR_W-1:0]                   next_ptr;
    logic [LANES-1:0][PTR_W-1:0]        lane_idx;
    logic [LANES-1:0]                   lane_vld;
    logic [NUM_SRC-1:0]                 grant;
    logic [NUM_SRC-1:0]                 conflict;

    logic [LANES-1:0]                   wr_en;
    logic [LANES-1:0][REG_W-1:0]        wr_reg;
    logic [LANES-1:0][DATA_W-1:0]       wr_data;
    logic [LANES-1:0][TAG_W-1:0]        wr_tag;

    // Index 0 sits in the most-significant field of every flat bus.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            occ[i]                        = slot[i].valid;
            regs[i]                       = slot[i].rd;
            src_ready_flat[NUM_SRC-1-i]   = ~slot[i].valid;
        end
        for (int l = 0; l < LANES; l++) begin
            wr_en_flat[LANES-1-l]                      = wr_en[l];
            wr_reg_flat[(LANES-1-l)*REG_W +: REG_W]    = wr_reg[l];
            wr_data_flat[(LANES-1-l)*DATA_W +: DATA_W] = wr_data[l];
            wr_tag_flat[(LANES-1-l)*TAG_W +: TAG_W]    = wr_tag[l];
        end
    end

    wb_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
        .occ      (occ),
        .regs     (regs),
        .rr_ptr   (rr_ptr),
        .lane_idx (lane_idx),
        .lane_vld (lane_vld),
        .grant    (grant),
        .conflict (conflict),
        .next_ptr (next_ptr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot    <= '0;
            wr_en   <= '0;
            wr_reg  <= '0;
            wr_data <= '0;
            wr_tag  <= '0;
            rr_ptr  <= '0;
        end else if (flush) begin
            slot    <= '0;
            wr_en   <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant[i]) begin
                    slot[i].valid <= 1'b0;
                end else if (src_valid_flat[NUM_SRC-1-i] &&
                             !slot[i].valid) begin
                    slot[i] <= '{
                        valid: 1'b1,
                        rd:    src_reg_flat[(NUM_SRC-1-i)*REG_W +: REG_W],
                        data:  src_data_flat[(NUM_SRC-1-i)*DATA_W +: DATA_W],
                        tag:   src_tag_flat[(NUM_SRC-1-i)*TAG_W +: TAG_W]
                    };
                end
            end
            for (int l = 0; l < LANES; l++) begin
                wr_en[l] <= lane_vld[l];
                if (lane_vld[l]) begin
                    wr_reg[l]  <= slot[lane_idx[l]].rd;
                    wr_data[l] <= slot[lane_idx[l]].data;
                    wr_tag[l]  <= slot[lane_idx[l]].tag;
                end
            end
            rr_ptr <= next_ptr;
        end
    end

`ifdef WB_ARB_STATS_EN
    logic [32:0] g_sum;
    logic [32:0] c_sum;

    always_comb begin
        g_sum = {1'b0, stat_grants} + 33'($countones(lane_vld));
        c_sum = {1'b0, stat_conflicts} + 33'($countones(conflict));
    end

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants    <= '0;
            stat_conflicts <= '0;
        end else if (!flush) begin
            stat_grants    <= g_sum[32] ? '1 : g_sum[31:0];
            stat_conflicts <= c_sum[32] ? '1 : c_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: accepted results are queued
// and matched against every enabled write lane.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [5:0]  valid;
    logic [5:0]  ready;
    logic [23:0] sreg;
    logic [95:0] sdata;
    logic [23:0] stag;
    logic [3:0]  wr_en;
    logic [15:0] wr_reg;
    logic [63:0] wr_data;
    logic [15:0] wr_tag;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_grants;
    logic [31:0] stat_conflicts;
`endif

    writeback_arbiter #(.NUM_SRC(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .src_valid_flat (valid),
        .src_ready_flat (ready),
        .src_reg_flat   (sreg),
        .src_data_flat  (sdata),
        .src_tag_flat   (stag),
        .wr_en_flat     (wr_en),
        .wr_reg_flat    (wr_reg),
        .wr_data_flat   (wr_data),
        .wr_tag_flat    (wr_tag)
`ifdef WB_ARB_STATS_EN
        ,
        .stat_grants    (stat_grants),
        .stat_conflicts (stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [3:0]  rd;
        logic [15:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    int   gcnt[6];
    int   glast[6];
    int   gmax[6];

    logic [3:0]  m_rd;
    logic [15:0] m_data;
    logic [3:0]  m_tag;
    int          m_j;
    int          m_s;

    // Scoreboard: every enabled lane must match a queued result.
    always @(negedge clk) begin
        cyc++;
        if (rst_n === 1'b1) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_en[3-l]) begin
                    m_rd   = wr_reg[(3-l)*4 +: 4];
                    m_data = wr_data[(3-l)*16 +: 16];
                    m_tag  = wr_tag[(3-l)*4 +: 4];
                    m_j    = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (m_j < 0 && exp_q[j].data == m_data) m_j = j;
                    n_total++;
                    if (m_j < 0) begin
                        $display("FAIL sb_unexpected lane%0d data=%0d reg=%0d",
                                 l, m_data, m_rd);
                    end else if (m_rd !== exp_q[m_j].rd ||
                                 m_tag !== exp_q[m_j].tag) begin
                        $display("FAIL sb_fields lane%0d reg=%0d tag=%0d want reg=%0d tag=%0d",
                                 l, m_rd, m_tag, exp_q[m_j].rd, exp_q[m_j].tag);
                        exp_q.delete(m_j);
                    end else begin
                        n_pass++;
                        m_s = exp_q[m_j].src;
                        gcnt[m_s]++;
                        if (glast[m_s] >= 0 && cyc - glast[m_s] > gmax[m_s])
                            gmax[m_s] = cyc - glast[m_s];
                        glast[m_s] = cyc;
                        exp_q.delete(m_j);
                    end
                end
            end
        end
    end

    task automatic drive(input int i, input logic [3:0] r,
                         input logic [15:0] d, input logic [3:0] t,
                         input bit track);
        valid[5-i]          = 1'b1;
        sreg[(5-i)*4 +: 4]  = r;
        sdata[(5-i)*16 +: 16] = d;
        stag[(5-i)*4 +: 4]  = t;
        if (track && ready[5-i]) exp_q.push_back('{i, r, d, t});
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        valid = '0;
        sreg  = '0;
        sdata = '0;
        stag  = '0;
        #2;
        n_total++;
        if (wr_en !== 4'h0 || wr_reg !== 16'h0 ||
            wr_data !== 64'h0 || wr_tag !== 16'h0 || ready !== 6'h3f)
            $display("FAIL reset_state en=%h reg=%h data=%h tag=%h rdy=%h want zeros rdy=3f",
                     wr_en, wr_reg, wr_data, wr_tag, ready);
        else n_pass++;
`ifdef WB_ARB_STATS_EN
        n_total++;
        if (stat_grants !== 32'd0 || stat_conflicts !== 32'd0)
            $display("FAIL reset_stats g=%0d c=%0d want 0 0",
                     stat_grants, stat_conflicts);
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_total++;
            if (wr_en !== 4'h0 || ready !== 6'h3f)
                $display("FAIL idle c%0d en=%b rdy=%b want 0000 111111",
                         c, wr_en, ready);
            else n_pass++;
        end
    endtask

    task automatic test_single();
        drive(2, 4'd5, 16'd70, 4'd3, 1'b1);
        @(negedge clk);
        valid = '0;
        n_total++;
        if (ready !== 6'b110111 || wr_en !== 4'h0)
            $display("FAIL single_hold rdy=%b en=%b want 110111 0000",
                     ready, wr_en);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 4'b1000 || wr_reg[15:12] !== 4'd5 ||
            wr_data[63:48] !== 16'd70 || wr_tag[15:12] !== 4'd3 ||
            ready !== 6'h3f)
            $display("FAIL single_write en=%b reg=%0d data=%0d tag=%0d rdy=%b",
                     wr_en, wr_reg[15:12], wr_data[63:48], wr_tag[15:12], ready);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_all_sources();
        do_flush();
        for (int i = 0; i < 6; i++)
            drive(i, 4'(i + 1), 16'(100 + i), 4'(i), 1'b1);
        @(negedge clk);
        valid = '0;
        @(negedge clk);
        n_total++;
        if (wr_en !== 4'b1111 || wr_reg !== {4'd1, 4'd2, 4'd3, 4'd4} ||
            wr_tag !== {4'd0, 4'd1, 4'd2, 4'd3} ||
            wr_data !== {16'd100, 16'd101, 16'd102, 16'd103})
            $display("FAIL all_first en=%b reg=%h tag=%h want 1111 1234 0123",
                     wr_en, wr_reg, wr_tag);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 4'b1100 || wr_reg[15:8] !== {4'd5, 4'd6} ||
            wr_tag[15:8] !== {4'd4, 4'd5} || dut.rr_ptr !== 3'd0)
            $display("FAIL all_second en=%b reg=%h tag=%h ptr=%0d want 1100 56 45 0",
                     wr_en, wr_reg[15:8], wr_tag[15:8], dut.rr_ptr);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 4'h0)
            $display("FAIL all_drained en=%b want 0000", wr_en);
        else n_pass++;
    endtask

    task automatic test_conflict();
        drive(0, 4'd7, 16'd200, 4'd1, 1'b1);
        drive(1, 4'd7, 16'd201, 4'd2, 1'b1);
        @(negedge clk);
        valid = '0;
        @(negedge clk);
        n_total++;
        if (wr_en !== 4'b1000 || wr_reg[15:12] !== 4'd7 ||
            wr_tag[15:12] !== 4'd1 || wr_data[63:48] !== 16'd200)
            $display("FAIL conflict_first en=%b reg=%0d tag=%0d data=%0d want 1000 7 1 200",
                     wr_en, wr_reg[15:12], wr_tag[15:12], wr_data[63:48]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (wr_en !== 4'b1000 || wr_reg[15:12] !== 4'd7 ||
            wr_tag[15:12] !== 4'd2 || wr_data[63:48] !== 16'd201)
            $display("FAIL conflict_second en=%b reg=%0d tag=%0d data=%0d want 1000 7 2 201",
                     wr_en, wr_reg[15:12], wr_tag[15:12], wr_data[63:48]);
        else n_pass++;
`ifdef WB_ARB_STATS_EN
        n_total++;
        if (stat_conflicts !== 32'd1 || stat_grants !== 32'd9)
            $display("FAIL conflict_stats c=%0d g=%0d want 1 9",
                     stat_conflicts, stat_grants);
        else n_pass++;
`endif
        @(negedge clk);
    endtask

    task automatic test_sustained();
        logic [15:0] d = 16'd1000;
        do_flush();
        for (int i = 0; i < 6; i++) begin
            gcnt[i]  = 0;
            glast[i] = -1;
            gmax[i]  = 0;
        end
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 6; i++) begin
                drive(i, 4'(i + 1), d, 4'(i), 1'b1);
                d++;
            end
            @(negedge clk);
        end
        valid = '0;
        repeat (4) @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL sustained_drain left=%0d want 0", exp_q.size());
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_total++;
            if (gcnt[i] < 6 || gmax[i] > 4 || gmax[i] == 0)
                $display("FAIL sustained_src%0d grants=%0d maxgap=%0d want >=6 1..4",
                         i, gcnt[i], gmax[i]);
            else n_pass++;
        end
    endtask

    task automatic test_flush_reset();
        for (int i = 0; i < 3; i++)
            drive(i, 4'(8 + i), 16'(300 + i), 4'(i), 1'b0);
        @(negedge clk);
        valid = '0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_total++;
        if (wr_en !== 4'h0 || ready !== 6'h3f)
            $display("FAIL flush_state en=%b rdy=%b want 0000 111111",
                     wr_en, ready);
        else n_pass++;
        repeat (4) begin
            @(negedge clk);
            n_total++;
            if (wr_en !== 4'h0)
                $display("FAIL flush_quiet en=%b want 0000", wr_en);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++)
            drive(i, 4'(8 + i), 16'(400 + i), 4'(i), 1'b1);
        @(negedge clk);
        valid = '0;
        for (int i = 3; i < 6; i++)
            drive(i, 4'(8 + i), 16'(500 + i), 4'(i), 1'b0);
        @(negedge clk);
        valid = '0;
        n_total++;
        if (wr_en !== 4'b1110)
            $display("FAIL rst_pre en=%b want 1110", wr_en);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (wr_en !== 4'h0 || wr_reg !== 16'h0 || wr_data !== 64'h0 ||
            wr_tag !== 16'h0 || ready !== 6'h3f)
            $display("FAIL rst_async en=%b reg=%h data=%h tag=%h rdy=%b",
                     wr_en, wr_reg, wr_data, wr_tag, ready);
        else n_pass++;
`ifdef WB_ARB_STATS_EN
        n_total++;
        if (stat_grants !== 32'd0 || stat_conflicts !== 32'd0)
            $display("FAIL rst_stats g=%0d c=%0d want 0 0",
                     stat_grants, stat_conflicts);
        else n_pass++;
`endif
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_total++;
            if (wr_en !== 4'h0)
                $display("FAIL rst_quiet en=%b want 0000", wr_en);
            else n_pass++;
        end
        #1;
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL final_queue left=%0d want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_sources();
        test_conflict();
        test_sustained();
        test_flush_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
